mem_bus_arbiter: RTL and testbench

- Shares one single-port external memory bus between the instruction-fetch port and the data port.
- The data port is driven by the MEM stage outputs: ce, we, addr, sel, data.
- Sequences each access through a registered req/ack handshake to the slave and returns read data to the requesting side.
- Generates per-port stall requests to the pipeline controller until that port's access completes.

---
 rtl/mem_bus_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-port (data / instruction fetch) arbiter onto one single-port memory bus.
// Optional round-robin grant when ARB_ROUND_ROBIN_EN is defined; default is data-over-fetch priority.
module mem_bus_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        d_ce_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [3:0]  d_sel_i,
  input  logic [31:0] d_wdata_i,
  output logic [31:0] d_rdata_o,
  output logic        d_stall_o,
  input  logic        i_ce_i,
  input  logic [31:0] i_addr_i,
  output logic [31:0] i_rdata_o,
  output logic        i_stall_o,
  input  logic        flush_i,
  output logic        s_req_o,
  output logic        s_we_o,
  output logic [31:0] s_addr_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_wdata_o,
  input  logic [31:0] s_rdata_i,
  input  logic        s_ack_i,
  output logic        bus_err_o
);

  typedef enum logic [2:0] {
    IDLE,
    BUSY_D,
    BUSY_I,
    DONE_D,
    DONE_I
  } state_t;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             flush_seen;
  logic             timeout_hit;
  logic             fetch_req;
  logic             grant_d;
  logic             grant_i;
  logic             discard;

  assign d_stall_o   = d_ce_i & (state != DONE_D);
  assign i_stall_o   = i_ce_i & (state != DONE_I) & ~flush_i;
  assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_LAST);
  assign fetch_req   = i_ce_i & ~flush_i;
  // A flushed fetch still has to finish on the bus, but its data is dropped.
  assign discard     = flush_i | flush_seen;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant;  // 1 = fetch was granted last

  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (d_ce_i && fetch_req) begin
      grant_d = last_grant;
      grant_i = ~last_grant;
    end else begin
      grant_d = d_ce_i;
      grant_i = fetch_req;
    end
  end
`else
  assign grant_d = d_ce_i;
  assign grant_i = fetch_req & ~d_ce_i;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      flush_seen <= 1'b0;
      s_req_o    <= 1'b0;
      s_we_o     <= 1'b0;
      s_addr_o   <= '0;
      s_sel_o    <= '0;
      s_wdata_o  <= '0;
      d_rdata_o  <= '0;
      i_rdata_o  <= '0;
      bus_err_o  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant <= 1'b1;
`endif
    end else begin
      bus_err_o <= 1'b0;
      case (state)
        IDLE: begin
          cnt        <= '0;
          flush_seen <= 1'b0;
          if (grant_d) begin
            s_req_o   <= 1'b1;
            s_we_o    <= d_we_i;
            s_addr_o  <= d_addr_i;
            s_sel_o   <= d_sel_i;
            s_wdata_o <= d_wdata_i;
            state     <= BUSY_D;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= 1'b0;
`endif
          end else if (grant_i) begin
            s_req_o   <= 1'b1;
            s_we_o    <= 1'b0;
            s_addr_o  <= i_addr_i;
            s_sel_o   <= 4'b1111;
            s_wdata_o <= '0;
            state     <= BUSY_I;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= 1'b1;
`endif
          end
        end

        BUSY_D: begin
          if (s_ack_i) begin
            s_req_o <= 1'b0;
            if (!s_we_o) d_rdata_o <= s_rdata_i;
            state <= DONE_D;
          end else if (timeout_hit) begin
            s_req_o   <= 1'b0;
            bus_err_o <= 1'b1;
            if (!s_we_o) d_rdata_o <= '0;
            state <= DONE_D;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        BUSY_I: begin
          if (flush_i) flush_seen <= 1'b1;
          if (s_ack_i) begin
            s_req_o <= 1'b0;
            if (discard) begin
              state <= IDLE;
            end else begin
              i_rdata_o <= s_rdata_i;
              state     <= DONE_I;
            end
          end else if (timeout_hit) begin
            s_req_o   <= 1'b0;
            bus_err_o <= 1'b1;
            if (discard) begin
              state <= IDLE;
            end else begin
              i_rdata_o <= '0;
              state     <= DONE_I;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE_D:  state <= IDLE;
        DONE_I:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a simple wait-state slave model.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        d_ce_i, d_we_i;
  logic [31:0] d_addr_i, d_wdata_i;
  logic [3:0]  d_sel_i;
  logic [31:0] d_rdata_o;
  logic        d_stall_o;
  logic        i_ce_i;
  logic [31:0] i_addr_i;
  logic [31:0] i_rdata_o;
  logic        i_stall_o;
  logic        flush_i;
  logic        s_req_o, s_we_o;
  logic [31:0] s_addr_o, s_wdata_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_rdata_i;
  logic        s_ack_i = 1'b0;
  logic        bus_err_o;

  int total = 0;
  int bad   = 0;

  bit slv_en   = 1'b0;
  int slv_wait = 0;
  int wcnt     = 0;

  int          req_cycles, dstall_cycles, istall_cycles, err_pulses, hold_cycles, nbursts;
  logic [31:0] burst_addr [8];
  logic [31:0] d_done_rdata, i_done_rdata;

  mem_bus_arbiter #(.TIMEOUT(4), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .d_ce_i(d_ce_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_sel_i(d_sel_i),
    .d_wdata_i(d_wdata_i), .d_rdata_o(d_rdata_o), .d_stall_o(d_stall_o),
    .i_ce_i(i_ce_i), .i_addr_i(i_addr_i), .i_rdata_o(i_rdata_o), .i_stall_o(i_stall_o),
    .flush_i(flush_i),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_sel_o(s_sel_o),
    .s_wdata_o(s_wdata_o), .s_rdata_i(s_rdata_i), .s_ack_i(s_ack_i), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  // Slave: acks after slv_wait BUSY cycles of waiting, single-cycle pulse.
  always @(posedge clk) begin
    #2;
    if (slv_en && s_req_o && !s_ack_i) begin
      if (wcnt == slv_wait) begin
        s_ack_i = 1'b1;
        wcnt    = 0;
      end else begin
        wcnt++;
      end
    end else begin
      s_ack_i = 1'b0;
      if (!s_req_o) wcnt = 0;
    end
  end

  task automatic reset_dut();
    rst = 1'b1;
    d_ce_i = 0; d_we_i = 0; d_addr_i = 0; d_sel_i = 0; d_wdata_i = 0;
    i_ce_i = 0; i_addr_i = 0; flush_i = 0; s_rdata_i = 0;
    slv_en = 1'b1; slv_wait = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Runs n cycles from +1ns of the current cycle; samples at +3ns.
  task automatic run_bus(input int n, input bit auto_drop);
    logic prev_req;
    bit   d_done, i_done;
    prev_req = s_req_o;
    req_cycles = 0; dstall_cycles = 0; istall_cycles = 0;
    err_pulses = 0; hold_cycles = 0; nbursts = 0;
    for (int c = 0; c < n; c++) begin
      #2;
      if (s_req_o) req_cycles++;
      if (s_req_o && !prev_req) begin
        if (nbursts < 8) burst_addr[nbursts] = s_addr_o;
        nbursts++;
      end
      prev_req = s_req_o;
      if (d_stall_o) dstall_cycles++;
      if (i_stall_o) istall_cycles++;
      if (bus_err_o) err_pulses++;
      if (s_req_o && s_we_o && s_sel_o == 4'b0011 && s_wdata_o == 32'h1234) hold_cycles++;
      d_done = d_ce_i && !d_stall_o;
      i_done = i_ce_i && !i_stall_o;
      if (d_done) d_done_rdata = d_rdata_o;
      if (i_done) i_done_rdata = i_rdata_o;
      @(posedge clk); #1;
      if (auto_drop) begin
        if (d_done) d_ce_i = 1'b0;
        if (i_done) i_ce_i = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    reset_dut();
    #2;
    total++;
    if ({s_req_o, s_we_o, s_addr_o, s_sel_o, s_wdata_o, bus_err_o, d_stall_o, i_stall_o} !== '0) begin
      bad++; $display("FAIL reset_outputs: got req=%b we=%b addr=%h sel=%b err=%b", s_req_o, s_we_o, s_addr_o, s_sel_o, bus_err_o);
    end
    #1;
    d_ce_i = 1; d_addr_i = 32'h10; s_rdata_i = 32'hFFFF0000;
    run_bus(5, 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    #2;
    total++;
    if (d_rdata_o !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", d_rdata_o); end
    #1;
    // Reset in the middle of a stuck fetch must drop the request.
    slv_en = 0; i_ce_i = 1; i_addr_i = 32'h20;
    run_bus(3, 0);
    total++;
    if (s_req_o !== 1'b1) begin bad++; $display("FAIL reset_pre_busy: req=%b want 1", s_req_o); end
    rst = 1'b1; i_ce_i = 0;
    @(posedge clk); #1 rst = 1'b0;
    #2;
    total++;
    if (s_req_o !== 1'b0 || bus_err_o !== 1'b0) begin bad++; $display("FAIL reset_mid_busy: req=%b err=%b want 0 0", s_req_o, bus_err_o); end
    #1;
  endtask

  task automatic test_data_read();
    reset_dut();
    d_ce_i = 1; d_addr_i = 32'h80; s_rdata_i = 32'hDEADBEEF; slv_wait = 0;
    run_bus(5, 1);
    total++;
    if (req_cycles !== 1) begin bad++; $display("FAIL rd_req_cycles: got %0d want 1", req_cycles); end
    total++;
    if (burst_addr[0] !== 32'h80) begin bad++; $display("FAIL rd_addr: got %h want 00000080", burst_addr[0]); end
    total++;
    if (dstall_cycles !== 2) begin bad++; $display("FAIL rd_stall_cycles: got %0d want 2", dstall_cycles); end
    total++;
    if (d_done_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data: got %h want deadbeef", d_done_rdata); end
  endtask

  task automatic test_contention();
    reset_dut();
    d_ce_i = 1; d_addr_i = 32'h100; i_ce_i = 1; i_addr_i = 32'h200;
    s_rdata_i = 32'h0BADF00D; slv_wait = 2;
    run_bus(12, 1);
    total++;
    if (nbursts !== 2) begin bad++; $display("FAIL ct_bursts: got %0d want 2", nbursts); end
    total++;
    if (burst_addr[0] !== 32'h100 || burst_addr[1] !== 32'h200) begin
      bad++; $display("FAIL ct_order: got %h,%h want 100,200", burst_addr[0], burst_addr[1]);
    end
    // data: IDLE + 3 BUSY; fetch waits that plus DONE_D, IDLE and 3 BUSY
    total++;
    if (dstall_cycles !== 4) begin bad++; $display("FAIL ct_dstall: got %0d want 4", dstall_cycles); end
    total++;
    if (istall_cycles !== 9) begin bad++; $display("FAIL ct_istall: got %0d want 9", istall_cycles); end
    total++;
    if (req_cycles !== 6) begin bad++; $display("FAIL ct_req_cycles: got %0d want 6", req_cycles); end
    total++;
    if (i_done_rdata !== 32'h0BADF00D) begin bad++; $display("FAIL ct_idata: got %h want 0badf00d", i_done_rdata); end
  endtask

  task automatic test_write();
    reset_dut();
    d_ce_i = 1; d_addr_i = 32'h44; s_rdata_i = 32'hCAFEF00D; slv_wait = 0;
    run_bus(5, 1);
    d_ce_i = 1; d_we_i = 1; d_sel_i = 4'b0011; d_wdata_i = 32'h1234; d_addr_i = 32'h48;
    s_rdata_i = 32'h99999999; slv_wait = 2;
    run_bus(8, 1);
    d_we_i = 0;
    total++;
    if (hold_cycles !== 3) begin bad++; $display("FAIL wr_hold: got %0d want 3", hold_cycles); end
    total++;
    if (req_cycles !== 3) begin bad++; $display("FAIL wr_req_cycles: got %0d want 3", req_cycles); end
    total++;
    if (d_rdata_o !== 32'hCAFEF00D) begin bad++; $display("FAIL wr_rdata_kept: got %h want cafef00d", d_rdata_o); end
  endtask

  task automatic test_timeout();
    reset_dut();
    i_ce_i = 1; i_addr_i = 32'h30; s_rdata_i = 32'h5A5A5A5A; slv_wait = 0;
    run_bus(5, 1);
    total++;
    if (i_done_rdata !== 32'h5A5A5A5A) begin bad++; $display("FAIL to_warm: got %h want 5a5a5a5a", i_done_rdata); end
    slv_en = 0; i_ce_i = 1; i_addr_i = 32'h300; i_done_rdata = 32'hFFFFFFFF;
    run_bus(8, 1);
    slv_en = 1;
    total++;
    if (req_cycles !== 4) begin bad++; $display("FAIL to_req_cycles: got %0d want 4", req_cycles); end
    total++;
    if (err_pulses !== 1) begin bad++; $display("FAIL to_err_pulses: got %0d want 1", err_pulses); end
    total++;
    if (istall_cycles !== 5) begin bad++; $display("FAIL to_istall: got %0d want 5", istall_cycles); end
    total++;
    if (i_done_rdata !== 32'h0) begin bad++; $display("FAIL to_rdata: got %h want 0", i_done_rdata); end
  endtask

  task automatic test_flush();
    int stall_bad;
    reset_dut();
    i_ce_i = 1; i_addr_i = 32'h40; s_rdata_i = 32'h13579BDF; slv_wait = 0;
    run_bus(5, 1);
    i_ce_i = 1; i_addr_i = 32'h400; s_rdata_i = 32'hAAAA5555; slv_wait = 3;
    stall_bad = 0;
    for (int c = 0; c < 8; c++) begin
      #2;
      if (c >= 2 && i_stall_o) stall_bad++;
      if (c == 5) begin
        total++;
        if (s_req_o !== 1'b0) begin bad++; $display("FAIL fl_req_drop: req=%b want 0", s_req_o); end
      end
      if (c == 6) begin
        total++;
        if (s_req_o !== 1'b1 || s_addr_o !== 32'h500) begin
          bad++; $display("FAIL fl_no_done: req=%b addr=%h want 1 00000500", s_req_o, s_addr_o);
        end
      end
      @(posedge clk); #1;
      if (c + 1 == 2) flush_i = 1;
      if (c + 1 == 3) begin flush_i = 0; i_ce_i = 0; end
      if (c + 1 == 5) begin d_ce_i = 1; d_addr_i = 32'h500; s_rdata_i = 32'h0; end
    end
    total++;
    if (stall_bad !== 0) begin bad++; $display("FAIL fl_istall: %0d stalled cycles want 0", stall_bad); end
    total++;
    if (i_rdata_o !== 32'h13579BDF) begin bad++; $display("FAIL fl_rdata_kept: got %h want 13579bdf", i_rdata_o); end
    run_bus(8, 1);
    // Flush in IDLE blocks the fetch grant.
    i_ce_i = 1; flush_i = 1; i_addr_i = 32'h600;
    #2;
    total++;
    if (i_stall_o !== 1'b0) begin bad++; $display("FAIL fl_idle_stall: got %b want 0", i_stall_o); end
    @(posedge clk); #3;
    total++;
    if (s_req_o !== 1'b0) begin bad++; $display("FAIL fl_idle_grant: req=%b want 0", s_req_o); end
    #(-0);
    i_ce_i = 0; flush_i = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_arbitration();
    reset_dut();
    d_ce_i = 1; d_addr_i = 32'h100; i_ce_i = 1; i_addr_i = 32'h200;
    s_rdata_i = 32'h1; slv_wait = 0;
    run_bus(12, 0);
    d_ce_i = 0; i_ce_i = 0;
    total++;
    if (nbursts !== 4) begin bad++; $display("FAIL arb_bursts: got %0d want 4", nbursts); end
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      logic [31:0] want = (k % 2 == 0) ? 32'h100 : 32'h200;
`else
      logic [31:0] want = 32'h100;
`endif
      total++;
      if (burst_addr[k] !== want) begin bad++; $display("FAIL arb_grant%0d: got %h want %h", k, burst_addr[k], want); end
    end
    run_bus(4, 0);
  endtask

  initial begin
    test_reset();
    test_data_read();
    test_contention();
    test_write();
    test_timeout();
    test_flush();
    test_arbitration();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
